pwm_duty_sequencer: RTL

//  Read-only master placed upstream of the PWM generator. It reads a table of 32-bit duty words from the
//  on-chip memory's single port and streams them out on a valid/ready interface to the PWM core.

---
 rtl/pwm_duty_sequencer_if.sv | 28 ++
 rtl/pwm_duty_sequencer.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/pwm_duty_sequencer_if.sv
// Memory read port plus duty-word stream between the sequencer (master) and
// the on-chip memory / PWM core (slave side).
interface pwm_duty_sequencer_if #(
    parameter int ADDR_W = 17,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] mem_address;
    logic              mem_chipselect;
    logic              mem_write;
    logic [3:0]        mem_byteenable;
    logic              mem_clken;
    logic [DATA_W-1:0] mem_readdata;
    logic [DATA_W-1:0] duty_data;
    logic              duty_valid;
    logic              duty_ready;

    modport master (
        output mem_address, mem_chipselect, mem_write, mem_byteenable, mem_clken,
        output duty_data, duty_valid,
        input  mem_readdata, duty_ready
    );

    modport slave (
        input  mem_address, mem_chipselect, mem_write, mem_byteenable, mem_clken,
        input  duty_data, duty_valid,
        output mem_readdata, duty_ready
    );
endinterface

// File: rtl/pwm_duty_sequencer.sv
// Reads a table of duty words from single-port memory and streams them to the
// PWM core through a small prefetch FIFO, in one-shot or continuous loop mode.
module pwm_duty_sequencer #(
    parameter int ADDR_W     = 17,
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] length,
    input  logic              loop_en,
    output logic              busy,
    output logic              done,
    pwm_duty_sequencer_if.master bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

    state_t            state, state_next;
    logic              done_next;
    logic              done_q;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] remaining;
    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W-1:0] length_q;
    logic              loop_q;
    logic              inflight;

    logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  rd_ptr, wr_ptr;
    logic [CNT_W-1:0]  count;

    logic issue, push, pop, last_issue;

    // Issue is gated by FIFO space counting the word still on its way back,
    // so the FIFO can never overflow.
    assign issue      = (state == FETCH) && ((count + CNT_W'(inflight)) < CNT_W'(FIFO_DEPTH))
                        && (remaining != '0);
    assign last_issue = issue && (remaining == ADDR_W'(1));
    assign push       = inflight;
    assign pop        = bus.duty_valid && bus.duty_ready;

    assign bus.mem_address    = addr;
    assign bus.mem_chipselect = issue;
    assign bus.mem_write      = 1'b0;
    assign bus.mem_byteenable = 4'hF;
    assign bus.mem_clken      = 1'b1;
    assign bus.duty_valid     = (count != '0);
    assign bus.duty_data      = (count != '0) ? fifo_mem[rd_ptr] : '0;
    assign busy               = (state != IDLE);
    assign done               = done_q;

    always_comb begin
        state_next = state;
        done_next  = 1'b0;
        if (stop) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        if (length != '0) state_next = FETCH;
                        else              done_next  = 1'b1;
                    end
                end
                FETCH: begin
                    if (last_issue && !loop_q) state_next = DRAIN;
                end
                DRAIN: begin
                    if ((count == '0) && !inflight) begin
                        state_next = IDLE;
                        done_next  = 1'b1;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            done_q    <= 1'b0;
            addr      <= '0;
            remaining <= '0;
            base_q    <= '0;
            length_q  <= '0;
            loop_q    <= 1'b0;
            inflight  <= 1'b0;
        end else begin
            state    <= state_next;
            done_q   <= done_next;
            inflight <= issue && !stop;
            if ((state == IDLE) && start && !stop) begin
                base_q    <= base_addr;
                length_q  <= length;
                loop_q    <= loop_en;
                addr      <= base_addr;
                remaining <= length;
            end else if (issue) begin
                // In loop mode the last word of the table rewinds to the start
                if (loop_q && (remaining == ADDR_W'(1))) begin
                    addr      <= base_q;
                    remaining <= length_q;
                end else begin
                    addr      <= addr + ADDR_W'(1);
                    remaining <= remaining - ADDR_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= bus.mem_readdata;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (stop) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end
endmodule
